// File: rtl/axi_tagctrl_r.sv
// Read-response half of the CHERI tag controller: merges tag-cache words with
// memory R beats and returns a tagged R stream under the original transaction ID.
module axi_tagctrl_r #(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned CapSize      = 128,
    parameter int unsigned TagBlockSize = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [AxiIdWidth-1:0]   desc_id_i,
    input  logic [AxiAddrWidth-1:0] desc_addr_i,
    input  logic [7:0]              desc_len_i,
    input  logic [2:0]              desc_size_i,
    input  logic [7:0]              desc_tag_len_i,
    input  logic                    tag_valid_i,
    output logic                    tag_ready_o,
    input  logic [TagBlockSize-1:0] tag_data_i,
    input  logic [1:0]              tag_resp_i,
    input  logic                    tag_last_i,
    input  logic                    mem_r_valid_i,
    output logic                    mem_r_ready_o,
    input  logic [AxiDataWidth-1:0] mem_r_data_i,
    input  logic [1:0]              mem_r_resp_i,
    input  logic                    mem_r_last_i,
    output logic                    slv_r_valid_o,
    input  logic                    slv_r_ready_i,
    output logic [AxiIdWidth-1:0]   slv_r_id_o,
    output logic [AxiDataWidth-1:0] slv_r_data_o,
    output logic [1:0]              slv_r_resp_o,
    output logic                    slv_r_last_o,
    output logic                    slv_r_user_o,
    output logic                    protocol_err_o
);
    localparam int unsigned CapOffW  = $clog2(CapSize / 8);
    localparam int unsigned TagIdxW  = $clog2(TagBlockSize);
    localparam int unsigned BlkLsb   = $clog2(TagBlockSize * CapSize / 8);
    localparam int unsigned TagCntW  = 9;

    typedef enum logic [1:0] {IDLE, TAG, STREAM, DRAIN} state_e;

    state_e                  state_q;
    logic [AxiIdWidth-1:0]   id_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic [7:0]              tag_len_q;
    logic [7:0]              beat_cnt_q;
    logic [TagCntW-1:0]      tag_cnt_q;
    logic                    tag_err_q;
    logic [1:0]              tag_resp_q;
    logic [TagBlockSize-1:0] tag_buf_q;
    logic                    out_valid_q;
    logic [AxiIdWidth-1:0]   out_id_q;
    logic [AxiDataWidth-1:0] out_data_q;
    logic [1:0]              out_resp_q;
    logic                    out_last_q;
    logic                    out_user_q;
    logic                    perr_q;

    logic [TagIdxW-1:0]      cap_idx;
    logic [AxiAddrWidth-1:0] addr_step;
    logic [AxiAddrWidth-1:0] next_addr;
    logic                    blk_change;
    logic                    beat_last;
    logic                    tag_cnt_last;
    logic                    tag_cnt_full;
    logic [1:0]              tag_resp_eff;
    logic [1:0]              beat_resp;
    logic                    desc_hs;
    logic                    tag_hs;
    logic                    mem_hs;

    // Address walk and tag-block bookkeeping for the beat currently in flight.
    assign cap_idx      = addr_q[CapOffW +: TagIdxW];
    assign addr_step    = AxiAddrWidth'(1) << size_q;
    assign next_addr    = (addr_q & ~(addr_step - AxiAddrWidth'(1))) + addr_step;
    assign blk_change   = next_addr[AxiAddrWidth-1:BlkLsb] != addr_q[AxiAddrWidth-1:BlkLsb];
    assign beat_last    = beat_cnt_q == len_q;
    assign tag_cnt_last = tag_cnt_q == {1'b0, tag_len_q};
    assign tag_cnt_full = tag_cnt_q == ({1'b0, tag_len_q} + TagCntW'(1));
    assign tag_resp_eff = tag_err_q ? tag_resp_q : 2'b00;
    assign beat_resp    = (mem_r_resp_i > tag_resp_eff) ? mem_r_resp_i : tag_resp_eff;

    assign desc_ready_o  = state_q == IDLE;
    assign tag_ready_o   = (state_q == TAG) || (state_q == DRAIN);
    assign mem_r_ready_o = (state_q == STREAM) && (!out_valid_q || slv_r_ready_i);

    assign desc_hs = desc_valid_i && desc_ready_o;
    assign tag_hs  = tag_valid_i && tag_ready_o;
    assign mem_hs  = mem_r_valid_i && mem_r_ready_o;

    assign slv_r_valid_o  = out_valid_q;
    assign slv_r_id_o     = out_id_q;
    assign slv_r_data_o   = out_data_q;
    assign slv_r_resp_o   = out_resp_q;
    assign slv_r_last_o   = out_last_q;
    assign slv_r_user_o   = out_user_q;
    assign protocol_err_o = perr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            tag_len_q   <= '0;
            beat_cnt_q  <= '0;
            tag_cnt_q   <= '0;
            tag_err_q   <= 1'b0;
            tag_resp_q  <= '0;
            tag_buf_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_resp_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            perr_q <= (mem_hs && (mem_r_last_i != beat_last)) ||
                      (tag_hs && (tag_last_i != tag_cnt_last));

            // Single-entry output register; a reload wins over the drain.
            if (mem_hs) begin
                out_valid_q <= 1'b1;
                out_id_q    <= id_q;
                out_data_q  <= mem_r_data_i;
                out_resp_q  <= beat_resp;
                out_last_q  <= beat_last;
                out_user_q  <= tag_err_q ? 1'b0 : tag_buf_q[cap_idx];
            end else if (slv_r_ready_i) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (desc_hs) begin
                        id_q       <= desc_id_i;
                        addr_q     <= desc_addr_i;
                        len_q      <= desc_len_i;
                        size_q     <= desc_size_i;
                        tag_len_q  <= desc_tag_len_i;
                        beat_cnt_q <= '0;
                        tag_cnt_q  <= '0;
                        tag_err_q  <= 1'b0;
                        tag_resp_q <= '0;
                        state_q    <= TAG;
                    end
                end
                TAG: begin
                    if (tag_hs) begin
                        tag_buf_q <= tag_data_i;
                        tag_cnt_q <= tag_cnt_q + TagCntW'(1);
                        if (tag_resp_i != 2'b00) begin
                            tag_err_q  <= 1'b1;
                            tag_resp_q <= tag_resp_i;
                        end
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (mem_hs) begin
                        addr_q     <= next_addr;
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        if (beat_last) begin
                            state_q <= tag_cnt_full ? IDLE : DRAIN;
                        end else if (blk_change) begin
                            state_q <= TAG;
                        end
                    end
                end
                DRAIN: begin
                    // Unused trailing tag words are swallowed so the tag stream stays aligned.
                    if (tag_hs) begin
                        tag_cnt_q <= tag_cnt_q + TagCntW'(1);
                        if (tag_cnt_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_tagctrl_r.sv
// Directed, table-driven bench for axi_tagctrl_r: bursts are queued as tag and
// memory beats, the returned R stream is collected and compared per beat.
module tb_axi_tagctrl_r;
    localparam int unsigned IdW = 4;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 128;
    localparam int unsigned TBS = 64;

    logic           clk_i;
    logic           rst_ni;
    logic           desc_valid_i;
    logic           desc_ready_o;
    logic [IdW-1:0] desc_id_i;
    logic [AW-1:0]  desc_addr_i;
    logic [7:0]     desc_len_i;
    logic [2:0]     desc_size_i;
    logic [7:0]     desc_tag_len_i;
    logic           tag_valid_i;
    logic           tag_ready_o;
    logic [TBS-1:0] tag_data_i;
    logic [1:0]     tag_resp_i;
    logic           tag_last_i;
    logic           mem_r_valid_i;
    logic           mem_r_ready_o;
    logic [DW-1:0]  mem_r_data_i;
    logic [1:0]     mem_r_resp_i;
    logic           mem_r_last_i;
    logic           slv_r_valid_o;
    logic           slv_r_ready_i;
    logic [IdW-1:0] slv_r_id_o;
    logic [DW-1:0]  slv_r_data_o;
    logic [1:0]     slv_r_resp_o;
    logic           slv_r_last_o;
    logic           slv_r_user_o;
    logic           protocol_err_o;

    axi_tagctrl_r dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_id_i(desc_id_i), .desc_addr_i(desc_addr_i), .desc_len_i(desc_len_i),
        .desc_size_i(desc_size_i), .desc_tag_len_i(desc_tag_len_i),
        .tag_valid_i(tag_valid_i), .tag_ready_o(tag_ready_o), .tag_data_i(tag_data_i),
        .tag_resp_i(tag_resp_i), .tag_last_i(tag_last_i),
        .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o),
        .mem_r_data_i(mem_r_data_i), .mem_r_resp_i(mem_r_resp_i), .mem_r_last_i(mem_r_last_i),
        .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
        .slv_r_id_o(slv_r_id_o), .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o),
        .slv_r_last_o(slv_r_last_o), .slv_r_user_o(slv_r_user_o),
        .protocol_err_o(protocol_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } mbeat_t;
    typedef struct { logic [TBS-1:0] data; logic [1:0] resp; logic last; } tbeat_t;
    typedef struct {
        logic [IdW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic user;
    } rbeat_t;
    typedef struct {
        logic [IdW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [7:0]     tag_len;
        logic [TBS-1:0] tag0;
        logic [TBS-1:0] tag1;
        logic [1:0]     tag_resp;
        logic [1:0]     mem_resp;
        int             stall_at;
        int             bad_last;
        logic [7:0]     user_exp;
        logic [1:0]     resp_exp;
        int             perr_exp;
    } vec_t;

    mbeat_t mq[$];
    tbeat_t tq[$];
    rbeat_t rq[$];
    vec_t   vecs[7];

    int   n_chk = 0;
    int   n_fail = 0;
    int   perr_seen, tag_fires, mem_fires, stall_at, stall_left;
    logic desc_pending;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int v, input int b);
        return {32'(v), 32'(b), 32'hA5A5_5A5A, ~32'(b)};
    endfunction

    // One clock: drive at negedge, sample handshakes just before posedge, retire after it.
    task automatic step();
        logic fd, ft, fm, stall_now;
        rbeat_t r;
        @(negedge clk_i);
        stall_now     = (stall_at >= 0) && (rq.size() >= stall_at) && (stall_left > 0);
        slv_r_ready_i = !stall_now;
        desc_valid_i  = desc_pending;
        tag_valid_i   = tq.size() > 0;
        tag_data_i    = (tq.size() > 0) ? tq[0].data : '0;
        tag_resp_i    = (tq.size() > 0) ? tq[0].resp : '0;
        tag_last_i    = (tq.size() > 0) ? tq[0].last : 1'b0;
        mem_r_valid_i = mq.size() > 0;
        mem_r_data_i  = (mq.size() > 0) ? mq[0].data : '0;
        mem_r_resp_i  = (mq.size() > 0) ? mq[0].resp : '0;
        mem_r_last_i  = (mq.size() > 0) ? mq[0].last : 1'b0;
        #1;
        if (protocol_err_o) perr_seen++;
        fd = desc_valid_i && desc_ready_o;
        ft = tag_valid_i && tag_ready_o;
        fm = mem_r_valid_i && mem_r_ready_o;
        if (slv_r_valid_o && slv_r_ready_i) begin
            r.id = slv_r_id_o; r.data = slv_r_data_o; r.resp = slv_r_resp_o;
            r.last = slv_r_last_o; r.user = slv_r_user_o;
            rq.push_back(r);
        end
        if (stall_now && slv_r_valid_o) chk("bp_mem_ready_while_full", 128'(mem_r_ready_o), 128'(0));
        @(posedge clk_i);
        if (fd) desc_pending = 1'b0;
        if (ft) begin void'(tq.pop_front()); tag_fires++; end
        if (fm) begin void'(mq.pop_front()); mem_fires++; end
        if (stall_now) stall_left--;
    endtask

    task automatic load_burst(input vec_t t, input int v);
        tbeat_t tb;
        mbeat_t mb;
        desc_id_i      = t.id;
        desc_addr_i    = t.addr;
        desc_len_i     = t.len;
        desc_size_i    = t.size;
        desc_tag_len_i = t.tag_len;
        desc_pending   = 1'b1;
        tq.delete(); mq.delete(); rq.delete();
        for (int j = 0; j <= int'(t.tag_len); j++) begin
            tb.data = (j == 0) ? t.tag0 : t.tag1;
            tb.resp = t.tag_resp;
            tb.last = (j == int'(t.tag_len));
            tq.push_back(tb);
        end
        for (int b = 0; b <= int'(t.len); b++) begin
            mb.data = mk_data(v, b);
            mb.resp = t.mem_resp;
            mb.last = (b == int'(t.len)) || (b == t.bad_last);
            mq.push_back(mb);
        end
        perr_seen = 0; tag_fires = 0; mem_fires = 0;
        stall_at = t.stall_at; stall_left = 5;
    endtask

    task automatic run_vec(input vec_t t, input int v);
        int cyc;
        int nb;
        load_burst(t, v);
        nb  = int'(t.len) + 1;
        cyc = 0;
        while (!(rq.size() == nb && tq.size() == 0 && mq.size() == 0) && cyc < 300) begin
            step();
            cyc++;
        end
        chk($sformatf("v%0d_beat_count", v), 128'(rq.size()), 128'(nb));
        for (int i = 0; i < rq.size() && i < nb; i++) begin
            chk($sformatf("v%0d_b%0d_id", v, i),   128'(rq[i].id),   128'(t.id));
            chk($sformatf("v%0d_b%0d_data", v, i), rq[i].data,       mk_data(v, i));
            chk($sformatf("v%0d_b%0d_resp", v, i), 128'(rq[i].resp), 128'(t.resp_exp));
            chk($sformatf("v%0d_b%0d_user", v, i), 128'(rq[i].user), 128'(t.user_exp[i]));
            chk($sformatf("v%0d_b%0d_last", v, i), 128'(rq[i].last), 128'(i == nb - 1));
        end
        chk($sformatf("v%0d_tag_beats", v), 128'(tag_fires), 128'(int'(t.tag_len) + 1));
        chk($sformatf("v%0d_protocol_err", v), 128'(perr_seen), 128'(t.perr_exp));
        @(negedge clk_i);
        #1;
        chk($sformatf("v%0d_desc_ready_after", v), 128'(desc_ready_o), 128'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_desc_ready"}, 128'(desc_ready_o), 128'(1));
        chk({tag, "_readies"}, 128'({tag_ready_o, mem_r_ready_o}), 128'(0));
        chk({tag, "_r_valid"}, 128'(slv_r_valid_o), 128'(0));
        chk({tag, "_r_fields"}, 128'({slv_r_id_o, slv_r_resp_o, slv_r_last_o, slv_r_user_o, protocol_err_o}), 128'(0));
        chk({tag, "_r_data"}, slv_r_data_o, 128'(0));
    endtask

    initial begin
        rst_ni = 1'b0;
        desc_valid_i = 1'b0; desc_id_i = '0; desc_addr_i = '0; desc_len_i = '0;
        desc_size_i = '0; desc_tag_len_i = '0;
        tag_valid_i = 1'b0; tag_data_i = '0; tag_resp_i = '0; tag_last_i = 1'b0;
        mem_r_valid_i = 1'b0; mem_r_data_i = '0; mem_r_resp_i = '0; mem_r_last_i = 1'b0;
        slv_r_ready_i = 1'b1;
        desc_pending = 1'b0; stall_at = -1; stall_left = 0;
        perr_seen = 0; tag_fires = 0; mem_fires = 0;

        vecs[0] = '{id:4'h5, addr:64'h8000_0020, len:8'd3, size:3'd4, tag_len:8'd0,
                    tag0:64'h24, tag1:64'h0, tag_resp:2'd0, mem_resp:2'd0, stall_at:-1,
                    bad_last:-1, user_exp:8'b0000_1001, resp_exp:2'd0, perr_exp:0};
        vecs[1] = '{id:4'hA, addr:64'h8000_03F0, len:8'd1, size:3'd4, tag_len:8'd1,
                    tag0:64'h8000_0000_0000_0000, tag1:64'hFFFF_FFFF_FFFF_FFFE, tag_resp:2'd0,
                    mem_resp:2'd0, stall_at:-1, bad_last:-1, user_exp:8'b0000_0001,
                    resp_exp:2'd0, perr_exp:0};
        vecs[2] = '{id:4'h3, addr:64'h8000_0100, len:8'd7, size:3'd4, tag_len:8'd0,
                    tag0:64'h0000_0000_00A5_0000, tag1:64'h0, tag_resp:2'd0, mem_resp:2'd0,
                    stall_at:3, bad_last:-1, user_exp:8'hA5, resp_exp:2'd0, perr_exp:0};
        vecs[3] = '{id:4'h7, addr:64'h8000_0040, len:8'd2, size:3'd4, tag_len:8'd0,
                    tag0:64'hFFFF_FFFF_FFFF_FFFF, tag1:64'h0, tag_resp:2'd2, mem_resp:2'd0,
                    stall_at:-1, bad_last:-1, user_exp:8'h00, resp_exp:2'd2, perr_exp:0};
        vecs[4] = '{id:4'h1, addr:64'h8000_0000, len:8'd0, size:3'd4, tag_len:8'd1,
                    tag0:64'h1, tag1:64'h0, tag_resp:2'd0, mem_resp:2'd0, stall_at:-1,
                    bad_last:-1, user_exp:8'b0000_0001, resp_exp:2'd0, perr_exp:0};
        vecs[5] = '{id:4'h9, addr:64'h8000_0080, len:8'd3, size:3'd4, tag_len:8'd0,
                    tag0:64'h0F00, tag1:64'h0, tag_resp:2'd0, mem_resp:2'd0, stall_at:-1,
                    bad_last:0, user_exp:8'h0F, resp_exp:2'd0, perr_exp:1};
        vecs[6] = '{id:4'hF, addr:64'h8000_000C, len:8'd3, size:3'd3, tag_len:8'd0,
                    tag0:64'h5, tag1:64'h0, tag_resp:2'd0, mem_resp:2'd1, stall_at:-1,
                    bad_last:-1, user_exp:8'b0000_1001, resp_exp:2'd1, perr_exp:0};

        #12;
        chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // Reset in the middle of a burst, after the second memory beat is accepted.
        load_burst(vecs[0], 10);
        for (int c = 0; c < 50 && mem_fires < 2; c++) step();
        chk("rst_mid_beats_before", 128'(mem_fires), 128'(2));
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rq.delete();
        mem_fires = 0;
        repeat (5) step();
        chk("rst_mid_no_beats_after", 128'(rq.size()), 128'(0));
        chk("rst_mid_no_mem_accept", 128'(mem_fires), 128'(0));
        tq.delete();
        mq.delete();

        run_vec(vecs[0], 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
